// File: rtl/instr_addr_sequencer.sv
// Instruction address sequencer: captures an address, holds it for a per-opcode
// number of cycles, and presents it through a fixed-depth output pipeline.
module instr_addr_sequencer #(
    parameter int AW    = 5,
    parameter int OPW   = 3,
    parameter int CW    = 3,
    parameter int DELAY = 2,
    parameter logic [(2**OPW)*CW-1:0] CYC_TABLE =
        {3'd3, 3'd4, 3'd5, 3'd5, 3'd5, 3'd5, 3'd3, 3'd0}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] address,
    input  logic [OPW-1:0] opcode,
    input  logic          stall,
    input  logic          flush,
    output logic [AW-1:0] out_address,
    output logic          out_start,
    output logic          busy
);

    logic [CW-1:0]       cnt;
    logic [AW-1:0]       hold_addr;
    logic                start_p;
    logic [DELAY*AW-1:0] addr_sr;
    logic [DELAY-1:0]    start_sr;
    logic [DELAY*AW-1:0] addr_next;
    logic [DELAY-1:0]    start_next;
    logic [CW-1:0]       table_hold;

    assign table_hold = CYC_TABLE[int'(opcode)*CW +: CW];

    // Stage 0 sits in the low bits; each advance shifts toward the output end.
    generate
        if (DELAY == 1) begin : g_single
            assign addr_next  = hold_addr;
            assign start_next = start_p;
        end else begin : g_multi
            assign addr_next  = {addr_sr[(DELAY-1)*AW-1:0], hold_addr};
            assign start_next = {start_sr[DELAY-2:0], start_p};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            hold_addr <= '0;
            start_p   <= 1'b0;
            addr_sr   <= '0;
            start_sr  <= '0;
        end else if (flush) begin
            cnt       <= '0;
            hold_addr <= '0;
            start_p   <= 1'b0;
            addr_sr   <= '0;
            start_sr  <= '0;
        end else if (!stall) begin
            if (cnt == '0) begin
                hold_addr <= address;
                cnt       <= table_hold;
                start_p   <= 1'b1;
            end else begin
                cnt       <= cnt - 1'b1;
                start_p   <= 1'b0;
            end
            addr_sr  <= addr_next;
            start_sr <= start_next;
        end
    end

    assign out_address = addr_sr[DELAY*AW-1 -: AW];
    assign out_start   = start_sr[DELAY-1];
    assign busy        = (cnt != '0);

endmodule

// File: tb/tb_instr_addr_sequencer.sv
// Directed bench for instr_addr_sequencer: default instance plus a wide/deep
// instance; expected outputs are queued when inputs are driven and popped one edge later.
module tb_instr_addr_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] address;
    logic [2:0] opcode;
    logic       stall, flush;
    logic [4:0] out_address;
    logic       out_start, busy;

    logic [7:0] b_address;
    logic [2:0] b_opcode;
    logic       b_stall, b_flush;
    logic [7:0] b_out_address;
    logic       b_out_start, b_busy;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];
    logic [4:0] hist[10];

    instr_addr_sequencer dut_a (
        .clk(clk), .rst_n(rst_n), .address(address), .opcode(opcode),
        .stall(stall), .flush(flush), .out_address(out_address),
        .out_start(out_start), .busy(busy)
    );

    instr_addr_sequencer #(
        .AW(8), .DELAY(3),
        .CYC_TABLE({3'd3, 3'd4, 3'd5, 3'd5, 3'd5, 3'd6, 3'd3, 3'd0})
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .address(b_address), .opcode(b_opcode),
        .stall(b_stall), .flush(b_flush), .out_address(b_out_address),
        .out_start(b_out_start), .busy(b_busy)
    );

    task automatic compare(input string tag, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed addr=%h start=%b busy=%b, expected addr=%h start=%b busy=%b",
                   tag, got[9:2], got[1], got[0], exp[9:2], exp[1], exp[0]);
        end
    endtask

    task automatic step_a(input logic [4:0] a, input logic [2:0] op, input logic st,
                          input logic fl, input logic [4:0] ea, input logic es,
                          input logic eb, input string tag);
        address = a;
        opcode  = op;
        stall   = st;
        flush   = fl;
        exp_q.push_back({3'b000, ea, es, eb});
        @(posedge clk);
        #1;
        compare(tag, {3'b000, out_address, out_start, busy}, exp_q.pop_front());
    endtask

    task automatic step_b(input logic [7:0] a, input logic [2:0] op,
                          input logic [7:0] ea, input logic es, input logic eb,
                          input string tag);
        b_address = a;
        b_opcode  = op;
        b_stall   = 1'b0;
        b_flush   = 1'b0;
        exp_q.push_back({ea, es, eb});
        @(posedge clk);
        #1;
        compare(tag, {b_out_address, b_out_start, b_busy}, exp_q.pop_front());
    endtask

    task automatic check_now_a(input string tag);
        exp_q.push_back(10'd0);
        compare(tag, {3'b000, out_address, out_start, busy}, exp_q.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        address = 5'h00; opcode = 3'd0; stall = 1'b0; flush = 1'b0;
        b_address = 8'h00; b_opcode = 3'd0; b_stall = 1'b1; b_flush = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_now_a("reset_outputs");
        #1 rst_n = 1'b1;

        // Opcode 1: three busy cycles, next capture on the fourth edge.
        step_a(5'h0A, 3'd1, 1'b0, 1'b0, 5'h00, 1'b0, 1'b1, "op1_e0");
        step_a(5'h0B, 3'd1, 1'b0, 1'b0, 5'h00, 1'b0, 1'b1, "op1_e1");
        step_a(5'h0C, 3'd5, 1'b0, 1'b0, 5'h0A, 1'b1, 1'b1, "op1_e2");
        step_a(5'h0D, 3'd5, 1'b0, 1'b0, 5'h0A, 1'b0, 1'b0, "op1_e3");
        step_a(5'h0E, 3'd1, 1'b0, 1'b0, 5'h0A, 1'b0, 1'b1, "op1_e4");
        step_a(5'h0F, 3'd2, 1'b0, 1'b0, 5'h0A, 1'b0, 1'b1, "op1_e5");
        step_a(5'h10, 3'd2, 1'b0, 1'b0, 5'h0E, 1'b1, 1'b1, "op1_e6");
        step_a(5'h11, 3'd2, 1'b0, 1'b0, 5'h0E, 1'b0, 1'b0, "op1_e7");

        // Back-to-back zero-hold captures with random addresses.
        for (int k = 0; k < 10; k++) begin
            hist[k] = 5'($urandom_range(0, 31));
            if (k < 2)
                step_a(hist[k], 3'd0, 1'b0, 1'b0, 5'h0E, 1'b0, 1'b0, "b2b");
            else
                step_a(hist[k], 3'd0, 1'b0, 1'b0, hist[k-2], 1'b1, 1'b0, "b2b");
        end

        // Opcode 2 with a three-cycle stall at cnt=3.
        step_a(5'h14, 3'd2, 1'b0, 1'b0, hist[8], 1'b1, 1'b1, "stall_f0");
        step_a(5'h00, 3'd0, 1'b0, 1'b0, hist[9], 1'b1, 1'b1, "stall_f1");
        step_a(5'h01, 3'd0, 1'b0, 1'b0, 5'h14, 1'b1, 1'b1, "stall_f2");
        step_a(5'h02, 3'd0, 1'b1, 1'b0, 5'h14, 1'b1, 1'b1, "stall_f3");
        step_a(5'h02, 3'd0, 1'b1, 1'b0, 5'h14, 1'b1, 1'b1, "stall_f4");
        step_a(5'h02, 3'd0, 1'b1, 1'b0, 5'h14, 1'b1, 1'b1, "stall_f5");
        step_a(5'h03, 3'd0, 1'b0, 1'b0, 5'h14, 1'b0, 1'b1, "stall_f6");
        step_a(5'h04, 3'd0, 1'b0, 1'b0, 5'h14, 1'b0, 1'b1, "stall_f7");
        step_a(5'h05, 3'd0, 1'b0, 1'b0, 5'h14, 1'b0, 1'b0, "stall_f8");
        step_a(5'h1B, 3'd0, 1'b0, 1'b0, 5'h14, 1'b0, 1'b0, "stall_f9");
        step_a(5'h1C, 3'd0, 1'b0, 1'b0, 5'h14, 1'b0, 1'b0, "stall_f10");
        step_a(5'h1D, 3'd3, 1'b0, 1'b0, 5'h1B, 1'b1, 1'b1, "stall_f11");

        // Flush together with stall at cnt=4, then immediate recapture.
        step_a(5'h00, 3'd0, 1'b0, 1'b0, 5'h1C, 1'b1, 1'b1, "flush_pre");
        step_a(5'h05, 3'd0, 1'b1, 1'b1, 5'h00, 1'b0, 1'b0, "flush_edge");
        step_a(5'h16, 3'd1, 1'b0, 1'b0, 5'h00, 1'b0, 1'b1, "flush_cap");
        step_a(5'h07, 3'd0, 1'b0, 1'b0, 5'h00, 1'b0, 1'b1, "flush_p1");
        step_a(5'h08, 3'd0, 1'b0, 1'b0, 5'h16, 1'b1, 1'b1, "flush_p2");
        step_a(5'h09, 3'd0, 1'b0, 1'b0, 5'h16, 1'b0, 1'b0, "flush_p3");

        // Asynchronous reset mid-instruction at cnt=4.
        step_a(5'h19, 3'd2, 1'b0, 1'b0, 5'h16, 1'b0, 1'b1, "rst_g0");
        step_a(5'h00, 3'd0, 1'b0, 1'b0, 5'h16, 1'b0, 1'b1, "rst_g1");
        #2 rst_n = 1'b0;
        #1 check_now_a("rst_async");
        step_a(5'h1F, 3'd3, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0, "rst_hold");
        rst_n = 1'b1;
        step_a(5'h12, 3'd0, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0, "rst_g3");
        step_a(5'h00, 3'd0, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0, "rst_g4");
        step_a(5'h00, 3'd0, 1'b0, 1'b0, 5'h12, 1'b1, 1'b0, "rst_g5");

        // Wide/deep instance: opcode 2 holds for six busy cycles, DELAY=3.
        step_b(8'hC5, 3'd2, 8'h00, 1'b0, 1'b1, "par_e0");
        step_b(8'h11, 3'd1, 8'h00, 1'b0, 1'b1, "par_e1");
        step_b(8'h22, 3'd1, 8'h00, 1'b0, 1'b1, "par_e2");
        step_b(8'h33, 3'd1, 8'hC5, 1'b1, 1'b1, "par_e3");
        step_b(8'h44, 3'd1, 8'hC5, 1'b0, 1'b1, "par_e4");
        step_b(8'h55, 3'd1, 8'hC5, 1'b0, 1'b1, "par_e5");
        step_b(8'h66, 3'd1, 8'hC5, 1'b0, 1'b0, "par_e6");
        step_b(8'h3C, 3'd0, 8'hC5, 1'b0, 1'b0, "par_e7");
        step_b(8'h5A, 3'd0, 8'hC5, 1'b0, 1'b0, "par_e8");
        step_b(8'h77, 3'd0, 8'hC5, 1'b0, 1'b0, "par_e9");
        step_b(8'h00, 3'd0, 8'h3C, 1'b1, 1'b0, "par_e10");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_addr_sequencer.md
INSTR_ADDR_SEQUENCER -- requirements
Module: instr_addr_sequencer

Interface
REQ-001 SHALL have parameter AW, default 5, address width in bits.
REQ-002 SHALL have parameter OPW, default 3, opcode width in bits.
REQ-003 SHALL have parameter CW, default 3, cycle-counter width in bits.
REQ-004 SHALL have parameter DELAY, default 2, output pipeline depth in stages; legal range 1..8.
REQ-005 SHALL have parameter CYC_TABLE, width (2**OPW)*CW, giving hold cycles per opcode; entry i is bits [i*CW +: CW]; default opcode 0..7 = 0,3,5,5,5,5,4,3.
REQ-006 Port: clk, input, 1, single clock; all state changes on its rising edge.
REQ-007 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-008 Port: address, input, AW, instruction address, sampled only on a capture edge.
REQ-009 Port: opcode, input, OPW, selects the CYC_TABLE entry, sampled only on a capture edge.
REQ-010 Port: stall, input, 1, freezes all internal state while high.
REQ-011 Port: flush, input, 1, aborts the current instruction and clears the pipeline.
REQ-012 Port: out_address, output, AW, captured address after DELAY stages.
REQ-013 Port: out_start, output, 1, one-cycle marker aligned with the first out_address cycle of each instruction.
REQ-014 Port: busy, output, 1, high while the hold counter is nonzero.

Function
REQ-015 SHALL hold internal registers cnt (CW bits), hold_addr (AW bits), start_p (1 bit), and DELAY-stage address and start pipelines.
REQ-016 A capture edge SHALL be a rising clk edge with cnt==0, stall==0 and flush==0.
REQ-017 On a capture edge the block SHALL load hold_addr<=address, cnt<=CYC_TABLE[opcode] and start_p<=1.
REQ-018 On a non-capture edge with cnt!=0, stall==0 and flush==0, the block SHALL apply cnt<=cnt-1 and start_p<=0, with hold_addr unchanged.
REQ-019 An instruction SHALL occupy CYC_TABLE[opcode]+1 cycles; a table entry of 0 SHALL allow a capture on every edge.
REQ-020 On every edge with stall==0 and flush==0, stage 0 SHALL load hold_addr/start_p and stage k SHALL load stage k-1.
REQ-021 out_address/out_start SHALL be the last pipeline stage, so a value captured at edge n appears after edge n+DELAY.
REQ-022 busy SHALL be combinational (cnt!=0).
REQ-023 While stall==1 and flush==0, cnt, hold_addr, start_p and all pipeline stages SHALL hold their values; stall extends the instruction one cycle per stalled cycle.
REQ-024 flush==1 SHALL take priority over stall and capture, and the next edge SHALL apply cnt<=0, start_p<=0, hold_addr<=0 and clear all pipeline stages to 0.
REQ-025 After a flush, the first edge with flush==0 and stall==0 SHALL be a capture edge.
REQ-026 The counter SHALL never decrement below 0 and SHALL never wrap.

Reset
REQ-027 While rst_n==0, cnt, hold_addr, start_p and all pipeline stages SHALL be 0 immediately, regardless of clk.
REQ-028 Consequently, during reset out_address==0, out_start==0 and busy==0.
REQ-029 The first rising edge after rst_n rises, with stall==0 and flush==0, SHALL be a capture edge.
REQ-030 Reset asserted mid-instruction SHALL discard the instruction; no partial output SHALL follow.

Verification
REQ-031 Reset case: assert rst_n=0 between edges while cnt=4 -> busy, out_address and out_start go to 0 at once, without a clock edge.
REQ-032 Opcode 3'b001 case: capture with address=5'h0A and opcode=3'b001 at edge 0, with address changing every cycle -> the following checks SHALL hold.
- busy is high for 3 cycles.
- The next capture occurs at edge 4.
- out_address=5'h0A after edges 2..5.
- out_start=1 only after edge 2.
REQ-033 Back-to-back case: opcode 3'b000 with address incrementing 0,1,2,... each edge -> busy stays 0 and out_address equals the address sampled 2 edges earlier.
REQ-034 Stall case: opcode 3'b010 captured, stall=1 for 3 cycles at cnt=3 -> cnt and out_address freeze, and the next capture is delayed by exactly 3 cycles (9 cycles total).
REQ-035 Flush case: flush=1 and stall=1 together at cnt=4 -> after the edge cnt=0, out_address=0 and out_start=0; the next edge with flush=0 and stall=0 captures the new address.
REQ-036 Parameter case: AW=8, DELAY=3, CYC_TABLE entry 2 = 6 -> capture 8'hC5 with opcode 2 -> the following checks SHALL hold.
- out_address=8'hC5 from edge 3 through edge 9.
- busy is high for 6 cycles.
